arb_n_rr: RTL and testbench

ARB_N_RR -- requirements
Module: arb_n_rr

---
 rtl/arb_n_rr.sv | 69 ++++++
 tb/tb_arb_n_rr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/arb_n_rr.sv
// arb_n_rr: N-way arbiter with fixed-priority or round-robin selection and
// an optional grant lock. Grant, grant_valid and grant_id are registered and
// appear one cycle after the request they answer.
module arb_n_rr #(
  parameter int N    = 4,
  parameter int MODE = 1,
  parameter int LOCK = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [IW-1:0] ptr;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  masked;
  logic [N-1:0]  search;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_id;
  logic [IW-1:0] next_ptr;
  logic          any_req;
  logic          hold;

  // Winner selection: look only at requests at or above ptr first, falling
  // back to the whole vector when none are there, which gives the wrap.
  // Fixed priority simply uses an all-ones mask so bit 0 always wins.
  always_comb begin
    hi_mask = '1;
    if (MODE == 1) hi_mask = ~((ONE << ptr) - ONE);
    masked = request & hi_mask;
    search = (|masked) ? masked : request;
    pick   = search & (~search + ONE);
  end

  // Encode the one-hot winner into its index; stays 0 when nothing is picked.
  always_comb begin
    pick_id = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_id = IW'(i);
    end
  end

  assign any_req  = |request;
  assign next_ptr = (pick_id == IW'(N - 1)) ? '0 : pick_id + IW'(1);
  assign hold     = (LOCK != 0) && (|(grant & request));

  // Register the grant; a locked holder keeps it untouched, otherwise
  // re-arbitrate and move the round-robin pointer past the new winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= '0;
    end else if (!hold) begin
      grant       <= pick;
      grant_valid <= any_req;
      grant_id    <= pick_id;
      if ((MODE == 1) && any_req) ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_arb_n_rr.sv
// tb_arb_n_rr: drives four arbiter configurations (fixed priority, round-robin,
// round-robin with lock, and a 5-way round-robin) from shared stimulus and
// checks every registered output against a behavioural reference model.
module tb_arb_n_rr;

  logic       clk;
  logic       rst;
  logic [3:0] req4;
  logic [4:0] req5;

  logic [3:0] g_fp, g_rr, g_lk;
  logic       v_fp, v_rr, v_lk;
  logic [1:0] id_fp, id_rr, id_lk;
  logic [4:0] g_r5;
  logic       v_r5;
  logic [2:0] id_r5;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    int          dut;
    logic [31:0] g;
    logic        v;
    int          id;
  } exp_t;

  exp_t sb[$];

  int    n_of[4]    = '{4, 4, 4, 5};
  int    mode_of[4] = '{0, 1, 1, 1};
  int    lock_of[4] = '{0, 0, 1, 0};
  string dname[4]   = '{"fp", "rr", "lock", "rr5"};
  int    m_ptr[4];
  int    m_hold[4];

  arb_n_rr #(.N(4), .MODE(0), .LOCK(0)) u_fp (
    .clk(clk), .rst(rst), .request(req4),
    .grant(g_fp), .grant_valid(v_fp), .grant_id(id_fp)
  );

  arb_n_rr #(.N(4), .MODE(1), .LOCK(0)) u_rr (
    .clk(clk), .rst(rst), .request(req4),
    .grant(g_rr), .grant_valid(v_rr), .grant_id(id_rr)
  );

  arb_n_rr #(.N(4), .MODE(1), .LOCK(1)) u_lk (
    .clk(clk), .rst(rst), .request(req4),
    .grant(g_lk), .grant_valid(v_lk), .grant_id(id_lk)
  );

  arb_n_rr #(.N(5), .MODE(1), .LOCK(0)) u_r5 (
    .clk(clk), .rst(rst), .request(req5),
    .grant(g_r5), .grant_valid(v_r5), .grant_id(id_r5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbiter: linear search from the start index with modulo wrap.
  task automatic modelStep(input int d, input logic r, input logic [31:0] q, input string tag);
    exp_t e;
    int   start;
    int   w;
    if (r) begin
      m_ptr[d]  = 0;
      m_hold[d] = -1;
    end else if ((lock_of[d] != 0) && (m_hold[d] >= 0) && q[m_hold[d]]) begin
      m_hold[d] = m_hold[d];
    end else begin
      w = -1;
      start = (mode_of[d] != 0) ? m_ptr[d] : 0;
      for (int k = 0; k < n_of[d]; k++) begin
        int idx;
        idx = (start + k) % n_of[d];
        if (w < 0 && q[idx]) w = idx;
      end
      m_hold[d] = w;
      if (w >= 0 && mode_of[d] != 0) m_ptr[d] = (w + 1) % n_of[d];
    end
    e.tag = tag;
    e.dut = d;
    e.g   = (m_hold[d] >= 0) ? (32'd1 << m_hold[d]) : 32'd0;
    e.v   = (m_hold[d] >= 0);
    e.id  = (m_hold[d] >= 0) ? m_hold[d] : 0;
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare it with the matching instance.
  task automatic checkOutput();
    exp_t        e;
    logic [31:0] ag;
    logic        av;
    logic [7:0]  aid;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin ag = {28'b0, g_fp}; av = v_fp; aid = {6'b0, id_fp}; end
        1:       begin ag = {28'b0, g_rr}; av = v_rr; aid = {6'b0, id_rr}; end
        2:       begin ag = {28'b0, g_lk}; av = v_lk; aid = {6'b0, id_lk}; end
        default: begin ag = {27'b0, g_r5}; av = v_r5; aid = {5'b0, id_r5}; end
      endcase
      vectors++;
      assert (ag === e.g) else begin
        miscompares++;
        $error("[TB] FAIL %s/%s grant: observed %b expected %b", e.tag, dname[e.dut], ag, e.g);
      end
      vectors++;
      assert (av === e.v) else begin
        miscompares++;
        $error("[TB] FAIL %s/%s grant_valid: observed %b expected %b", e.tag, dname[e.dut], av, e.v);
      end
      vectors++;
      assert (aid === 8'(e.id)) else begin
        miscompares++;
        $error("[TB] FAIL %s/%s grant_id: observed %0d expected %0d", e.tag, dname[e.dut], aid, e.id);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, record expectations,
  // then check just after the rising edge that samples them.
  task automatic applyStimulus(input logic r, input logic [3:0] q4, input logic [4:0] q5, input string tag);
    @(negedge clk);
    rst  = r;
    req4 = q4;
    req5 = q5;
    for (int d = 0; d < 4; d++) begin
      modelStep(d, r, (d == 3) ? {27'b0, q5} : {28'b0, q4}, tag);
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       r;
    logic [3:0] q4;
    logic [4:0] q5;
    rst  = 1'b1;
    req4 = '0;
    req5 = '0;
    for (int d = 0; d < 4; d++) begin
      m_ptr[d]  = 0;
      m_hold[d] = -1;
    end

    // Reset held three cycles with every request active.
    applyStimulus(1'b1, 4'b1111, 5'b11111, "reset");
    applyStimulus(1'b1, 4'b1111, 5'b11111, "reset");
    applyStimulus(1'b1, 4'b1111, 5'b11111, "reset");

    // Fixed-priority picks.
    applyStimulus(1'b0, 4'b0110, 5'b00110, "fixed_0110");
    applyStimulus(1'b0, 4'b0100, 5'b00100, "fixed_0100");

    // Round-robin rotation, wrap and skip; 5-way instance wraps at index 4.
    applyStimulus(1'b1, 4'b0000, 5'b00000, "reset");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b1111, 5'b11111, "rr_all");
    applyStimulus(1'b0, 4'b1001, 5'b10001, "rr_wrap");
    applyStimulus(1'b0, 4'b0100, 5'b10000, "rr_skip");
    applyStimulus(1'b0, 4'b0000, 5'b10001, "rr_idle");
    applyStimulus(1'b0, 4'b0000, 5'b00000, "rr_idle");

    // Lock: holder keeps grant, then hands over with no idle cycle.
    applyStimulus(1'b1, 4'b0000, 5'b00000, "reset");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0011, 5'b00011, "lock_hold");
    applyStimulus(1'b0, 4'b0010, 5'b00010, "lock_handover");
    applyStimulus(1'b0, 4'b0010, 5'b00010, "single_req");

    // Reset in the middle of a grant restarts the pointer at 0.
    applyStimulus(1'b1, 4'b0000, 5'b00000, "reset");
    applyStimulus(1'b0, 4'b0100, 5'b00100, "pre_reset");
    applyStimulus(1'b1, 4'b1111, 5'b11111, "mid_reset");
    applyStimulus(1'b0, 4'b1111, 5'b11111, "post_reset");

    // Random traffic with occasional resets.
    for (int i = 0; i < 60; i++) begin
      r  = ($urandom_range(15, 0) == 0);
      q4 = 4'($urandom);
      q5 = 5'($urandom);
      applyStimulus(r, q4, q5, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
